// File: rtl/piso_shift_ctrl.sv
// piso_shift_ctrl
//   Parallel-in / serial-out shifter with valid/ready handshakes on both sides.
//   A frame of 1..DATA_WIDTH bits is captured on a load and sent one bit per
//   accepted transfer, either LSB-first or MSB-first.
//
// Ports
//   clk         : single clock, rising edge
//   reset       : synchronous, active-high reset
//   din         : parallel frame, bit 0 is the LSB
//   din_len     : number of bits to send (0 or > DATA_WIDTH means DATA_WIDTH)
//   msb_first   : 1 = din[len-1] first, 0 = din[0] first (sampled at load)
//   din_valid   : load request
//   din_ready   : load can be accepted this cycle
//   dout        : current serial bit
//   dout_valid  : dout carries a frame bit
//   dout_last   : dout is the final bit of the frame
//   dout_ready  : sink consumes dout this cycle
//
// State table
//   state | meaning
//   IDLE  | no frame held, waiting for a load
//   SHIFT | frame held, one or more bits remaining, shreg_q[0] is on dout

module piso_shift_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [LEN_WIDTH-1:0]  din_len,
  input  logic                  msb_first,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  dout,
  output logic                  dout_valid,
  output logic                  dout_last,
  input  logic                  dout_ready
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [LEN_WIDTH-1:0] FULL_LEN = LEN_WIDTH'(DATA_WIDTH);
  localparam logic [LEN_WIDTH-1:0] ONE      = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] TWO      = LEN_WIDTH'(2);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  last_q, last_d;

  logic [LEN_WIDTH-1:0]  len_eff;
  logic [DATA_WIDTH-1:0] din_rev;
  logic [DATA_WIDTH-1:0] frame;
  logic                  xfer;
  logic                  load;

  assign len_eff = ((din_len == '0) || (din_len > FULL_LEN)) ? FULL_LEN : din_len;

  always_comb begin
    din_rev = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      din_rev[i] = din[DATA_WIDTH-1-i];
    end
  end

  // The frame is stored so the next bit to send is always at bit 0 and the
  // unused upper bits are zero. For MSB-first the fully reversed word is
  // shifted down so din[len-1] lands at bit 0 and din[0] at bit len-1.
  // For LSB-first the bits above len-1 are masked off (a shift by
  // DATA_WIDTH yields a zero, i.e. an all-ones mask).
  assign frame = msb_first ? (din_rev >> (FULL_LEN - len_eff))
                           : (din & ~({DATA_WIDTH{1'b1}} << len_eff));

  assign dout       = shreg_q[0];
  assign dout_valid = (state_q == SHIFT);
  assign dout_last  = last_q;

  assign xfer      = dout_valid && dout_ready;
  assign din_ready = !reset && ((state_q == IDLE) || (dout_valid && last_q && dout_ready));
  assign load      = din_valid && din_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  // A load is only possible in IDLE or on the last-bit transfer, so giving
  // it priority over the transfer gives back-to-back frames with no gap.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (load) begin
      state_d = SHIFT;
      shreg_d = frame;
      cnt_d   = len_eff;
      last_d  = (len_eff == ONE);
    end else if (xfer) begin
      if (cnt_q == ONE) begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
        last_d  = 1'b0;
      end else begin
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q - ONE;
        last_d  = (cnt_q == TWO);
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_ctrl.sv
module tb_piso_shift_ctrl;

  localparam int DW = 8;
  localparam int LW = $clog2(DW + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] din;
  logic [LW-1:0] din_len;
  logic          msb_first;
  logic          din_valid;
  logic          din_ready;
  logic          dout;
  logic          dout_valid;
  logic          dout_last;
  logic          dout_ready;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the bits still to be sent, front = bit on dout.
  bit q[$];
  logic [31:0] log_bits;

  piso_shift_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_len    (din_len),
    .msb_first  (msb_first),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .dout_ready (dout_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model at
  // the rising edge using the same inputs the DUT sampled.
  task automatic cyc();
    int  len;
    bit  e_valid, e_last, e_ready, e_dout;
    @(negedge clk);
    e_valid = (q.size() > 0);
    e_dout  = e_valid ? q[0] : 1'b0;
    e_last  = (q.size() == 1);
    e_ready = !reset && ((q.size() == 0) || (q.size() == 1 && dout_ready));
    chk("dout_valid", 32'(dout_valid), 32'(e_valid));
    chk("dout",       32'(dout),       32'(e_dout));
    chk("dout_last",  32'(dout_last),  32'(e_last));
    chk("din_ready",  32'(din_ready),  32'(e_ready));
    if (dout_valid && dout_ready) log_bits = {log_bits[30:0], dout};
    @(posedge clk);
    if (reset) begin
      q.delete();
    end else begin
      if (e_valid && dout_ready) void'(q.pop_front());
      if (din_valid && e_ready) begin
        len = (din_len == 0 || din_len > DW) ? DW : int'(din_len);
        q.delete();
        for (int k = 0; k < len; k++)
          q.push_back(msb_first ? din[len-1-k] : din[k]);
      end
    end
    #1;
  endtask

  task automatic load(input logic [DW-1:0] d, input int len, input logic msb);
    din = d; din_len = LW'(len); msb_first = msb; din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; din = '0; din_len = '0; msb_first = 1'b0;
    din_valid = 1'b0; dout_ready = 1'b1; log_bits = '0;
    repeat (2) @(posedge clk);
    #1;
    din_valid = 1'b1;
    cyc();                         // in reset: din_ready must be 0
    din_valid = 1'b0;
    reset = 1'b0;
    cyc();                         // first cycle after reset: din_ready=1

    // LSB-first full frame
    log_bits = '0;
    load(8'hC1, 8, 1'b0);
    repeat (9) cyc();
    chk("seq_c1_lsb", log_bits, 32'b10000011);

    // MSB-first full frame
    log_bits = '0;
    load(8'hC1, 8, 1'b1);
    repeat (9) cyc();
    chk("seq_c1_msb", log_bits, 32'b11000001);

    // Short frames, upper bits never sent
    log_bits = '0;
    load(8'hF6, 3, 1'b1);
    repeat (4) cyc();
    chk("seq_f6_msb3", log_bits, 32'b110);
    log_bits = '0;
    load(8'hF6, 3, 1'b0);
    repeat (4) cyc();
    chk("seq_f6_lsb3", log_bits, 32'b011);

    // Back-to-back frames with din_valid held
    log_bits = '0;
    din = 8'hC1; din_len = LW'(8); msb_first = 1'b0; din_valid = 1'b1;
    cyc();
    din = 8'h06; din_len = LW'(3);
    repeat (8) cyc();
    din_valid = 1'b0;
    repeat (4) cyc();
    chk("seq_b2b", log_bits, 32'b10000011011);

    // Stall after the second bit, with an ignored load pulse
    log_bits = '0;
    load(8'hC1, 8, 1'b0);
    cyc();
    dout_ready = 1'b0;
    cyc();
    din = 8'hFF; din_len = LW'(2); msb_first = 1'b1; din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    cyc();
    chk("stall_dout", 32'(dout), 32'd0);
    dout_ready = 1'b1;
    repeat (8) cyc();
    chk("seq_stall", log_bits, 32'b10000011);

    // Reset mid-frame, then a len=0 frame
    load(8'hA5, 8, 1'b0);
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    log_bits = '0;
    load(8'h01, 0, 1'b0);
    repeat (9) cyc();
    chk("seq_len0", log_bits, 32'b10000000);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 99) == 0);
      din        = DW'($urandom);
      din_len    = LW'($urandom_range(0, (1 << LW) - 1));
      msb_first  = 1'($urandom);
      din_valid  = ($urandom_range(0, 3) != 0);
      dout_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_shift_ctrl.md
PISO_SHIFT_CTRL -- requirements
Module: piso_shift_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: maximum frame length in bits (>= 2).
REQ-002 SHALL have parameter LEN_WIDTH, default $clog2(DATA_WIDTH+1): width of din_len.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port din  input  DATA_WIDTH  parallel frame; bit 0 is the LSB.
REQ-006 SHALL have port din_len  input  LEN_WIDTH  number of bits to send from din.
REQ-007 SHALL have port msb_first  input  1  serial order: 1 = din[len-1] first, 0 = din[0] first.
REQ-008 SHALL have port din_valid  input  1  load request.
REQ-009 SHALL have port din_ready  output  1  load can be accepted this cycle.
REQ-010 SHALL have port dout  output  1  current serial bit.
REQ-011 SHALL have port dout_valid  output  1  dout carries a frame bit.
REQ-012 SHALL have port dout_last  output  1  dout is the final bit of the frame.
REQ-013 SHALL have port dout_ready  input  1  sink consumes dout this cycle.

Function
REQ-014 SHALL have two states: IDLE (no frame held) and SHIFT (frame held, bits remaining >= 1).
REQ-015 A load SHALL occur on a clock edge where din_valid && din_ready; din, din_len and msb_first are captured together.
REQ-016 din_len of 0 or greater than DATA_WIDTH SHALL be treated as DATA_WIDTH.
REQ-017 After a load, the next cycle SHALL be in SHIFT with dout_valid=1 and dout = first bit of the frame: a 1-cycle load-to-output latency.
REQ-018 dout, dout_valid and dout_last SHALL be driven from registers only, with no combinational path from din or din_valid.
REQ-019 Bit transfer SHALL occur when dout_valid && dout_ready; the following cycle shows the next bit in the captured order.
REQ-020 With dout_ready=0 in SHIFT, dout, dout_valid, dout_last and the remaining-bit count SHALL hold.
REQ-021 dout_last SHALL be 1 exactly when the remaining-bit count is 1.
REQ-022 On transfer of the last bit with no simultaneous load, the block SHALL return to IDLE with dout_valid=0, dout_last=0 and dout=0.
REQ-023 din_ready SHALL equal (state==IDLE) || (dout_valid && dout_last && dout_ready), and SHALL be 0 while reset is asserted.
REQ-024 On a simultaneous last-bit transfer and load, the new frame's first bit SHALL appear the next cycle with no idle gap (back-to-back).
REQ-025 msb_first SHALL be sampled only at load; changes mid-frame SHALL have no effect.
REQ-026 MSB-first frames shorter than DATA_WIDTH SHALL output din[len-1] down to din[0]; bits above len-1 SHALL never appear on dout.
REQ-027 din_valid asserted while din_ready=0 SHALL be ignored and SHALL not corrupt the frame in flight.

Reset
REQ-028 While reset=1 at a clock edge: state<=IDLE, shift register and count<=0, dout=0, dout_valid=0, dout_last=0.
REQ-029 Reset SHALL take priority over load and transfer, and SHALL discard any partially sent frame.
REQ-030 In the first cycle after reset deasserts, din_ready=1.

Verification (DATA_WIDTH=8)
REQ-031 Load din=8'hC1, len=8, msb_first=0, dout_ready=1 -> dout over 8 cycles = 1,0,0,0,0,0,1,1; dout_last only on the 8th; then dout_valid=0.
REQ-032 Load din=8'hC1, len=8, msb_first=1 -> dout = 1,1,0,0,0,0,0,1.
REQ-033 Load din=8'hF6, len=3, msb_first=1 -> dout = 1,1,0 with dout_last on the 3rd; with msb_first=0 -> 0,1,1; bits 7..3 never appear.
REQ-034 Frame A=8'hC1 (len 8, LSB-first), then B=8'h06 (len 3, LSB-first) with din_valid held -> 11 consecutive valid cycles: 1,0,0,0,0,0,1,1,0,1,1; din_ready=1 only on A's last cycle.
REQ-035 dout_ready=0 for 3 cycles after the 2nd bit of 8'hC1 (LSB-first) -> dout holds 0 and dout_valid holds 1; the sequence then resumes unchanged. din_valid pulsed during the stall is ignored.
REQ-036 reset=1 on the 4th bit of a frame -> next cycle dout_valid=0, dout=0, din_ready=1; a new load of din=8'h01, len=0 then yields 8 bits 1,0,0,0,0,0,0,0.
